ntt_ctrl: RTL and testbench

- Sequences one shared non-pipelined butterfly unit (bt_unit) over a 256-point in-place forward NTT (Cooley-Tukey, q = 7681, 14-bit coefficients) held in a dual-port coefficient RAM.
- Generates RAM read/write addresses and the twiddle index, holds butterfly operands stable, and handshakes with the unit via en/valid.
- Sits between the top-level polynomial engine (start/done) and the RAM + butterfly + zeta ROM.

---
 rtl/ntt_pkg.sv | 29 ++
 rtl/ntt_addr_gen.sv | 80 ++++++++
 rtl/ntt_ctrl.sv | 151 +++++++++++++++
 tb/tb_ntt_ctrl.sv | 349 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ntt_pkg.sv
// ============================================================================
// Module      : ntt_pkg
// Description : Shared constants and FSM state type for the 256-point NTT
//               controller and its address generator.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ntt_pkg;

  localparam int N       = 256;   // transform length
  localparam int LOG_N   = 8;     // number of butterfly layers
  localparam int BIT_LEN = 14;    // coefficient width
  localparam int ADDR_W  = 8;     // RAM address width (= LOG_N)
  localparam int Q       = 7681;  // NTT modulus

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    READ  = 3'd1,
    LOAD  = 3'd2,
    ISSUE = 3'd3,
    WAIT  = 3'd4,
    WRITE = 3'd5,
    DONE  = 3'd6
  } state_t;

endpackage

`default_nettype wire

// File: rtl/ntt_addr_gen.sv
// ============================================================================
// Module      : ntt_addr_gen
// Description : Cooley-Tukey loop counters (len / start_j / j / k) for an
//               in-place forward NTT. Produces the butterfly address pair,
//               the twiddle index and a flag marking the final butterfly.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ntt_addr_gen
  import ntt_pkg::*;
(
  input  logic              clk,
  input  logic              reset,     // asynchronous, active-low
  input  logic              init,      // restart the loop nest
  input  logic              advance,   // current butterfly written, step on
  output logic [ADDR_W-1:0] addr_a,
  output logic [ADDR_W-1:0] addr_b,
  output logic [ADDR_W-1:0] zeta_idx,
  output logic              last
);

  localparam logic [ADDR_W:0]   C_N_EXT    = (ADDR_W+1)'(N);
  localparam logic [ADDR_W-1:0] C_LEN_INIT = ADDR_W'(N / 2);

  logic [ADDR_W-1:0] r_len;
  logic [ADDR_W-1:0] r_start_j;
  logic [ADDR_W-1:0] r_j;
  logic [ADDR_W-1:0] r_k;

  // One extra bit so start_j + 2*len == N is representable.
  logic [ADDR_W:0] w_j_next;
  logic [ADDR_W:0] w_grp_end;
  logic [ADDR_W:0] w_next_start;
  logic            w_group_done;
  logic            w_layer_done;

  assign w_j_next     = {1'b0, r_j} + 1'b1;
  assign w_grp_end    = {1'b0, r_start_j} + {1'b0, r_len};
  assign w_next_start = w_grp_end + {1'b0, r_len};
  assign w_group_done = (w_j_next == w_grp_end);
  assign w_layer_done = (w_next_start == C_N_EXT);

  assign last     = w_group_done && w_layer_done && (r_len == ADDR_W'(1));
  assign addr_a   = r_j;
  assign addr_b   = r_j + r_len;   // never exceeds N-1 by construction
  assign zeta_idx = r_k;

  // Step through j, then start_j (new twiddle), then len (new layer).
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_len     <= C_LEN_INIT;
      r_start_j <= '0;
      r_j       <= '0;
      r_k       <= ADDR_W'(1);
    end else if (init || (advance && last)) begin
      r_len     <= C_LEN_INIT;
      r_start_j <= '0;
      r_j       <= '0;
      r_k       <= ADDR_W'(1);
    end else if (advance) begin
      if (w_group_done) begin
        r_k <= r_k + 1'b1;
        if (w_layer_done) begin
          r_len     <= r_len >> 1;
          r_start_j <= '0;
          r_j       <= '0;
        end else begin
          r_start_j <= w_next_start[ADDR_W-1:0];
          r_j       <= w_next_start[ADDR_W-1:0];
        end
      end else begin
        r_j <= w_j_next[ADDR_W-1:0];
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/ntt_ctrl.sv
// ============================================================================
// Module      : ntt_ctrl
// Description : Sequencer for a 256-point in-place forward NTT over one
//               shared, non-pipelined butterfly unit. Per butterfly:
//               READ -> LOAD -> ISSUE -> WAIT (until bt_valid) -> WRITE.
//               Optional macro NTT_CTRL_CYCLE_CNT_EN adds a saturating
//               16-bit busy-cycle counter output (cycle_cnt).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ntt_ctrl
  import ntt_pkg::*;
(
  input  logic               clk,
  input  logic               reset,      // asynchronous, active-low
  input  logic               start,
  output logic               busy,
  output logic               done,
  output logic               rd_en,
  output logic [ADDR_W-1:0]  rd_addr_a,
  output logic [ADDR_W-1:0]  rd_addr_b,
  input  logic [BIT_LEN-1:0] rd_data_a,
  input  logic [BIT_LEN-1:0] rd_data_b,
  output logic [ADDR_W-1:0]  zeta_idx,
  output logic               bt_en,
  output logic [BIT_LEN-1:0] bt_a,
  output logic [BIT_LEN-1:0] bt_b,
  input  logic [BIT_LEN-1:0] bt_a_res,
  input  logic [BIT_LEN-1:0] bt_b_res,
  input  logic               bt_valid,
  output logic               wr_en,
  output logic [ADDR_W-1:0]  wr_addr_a,
  output logic [ADDR_W-1:0]  wr_addr_b,
  output logic [BIT_LEN-1:0] wr_data_a,
  output logic [BIT_LEN-1:0] wr_data_b
`ifdef NTT_CTRL_CYCLE_CNT_EN
  ,
  output logic [15:0]        cycle_cnt
`endif
);

  state_t r_state;
  state_t w_state_nxt;

  logic              w_init;
  logic              w_advance;
  logic              w_last;
  logic [ADDR_W-1:0] w_addr_a;
  logic [ADDR_W-1:0] w_addr_b;
  logic [ADDR_W-1:0] w_zeta_idx;

  logic [BIT_LEN-1:0] r_bt_a;
  logic [BIT_LEN-1:0] r_bt_b;
  logic [BIT_LEN-1:0] r_wr_data_a;
  logic [BIT_LEN-1:0] r_wr_data_b;

  assign w_init    = (r_state == IDLE) && start;
  assign w_advance = (r_state == WRITE);

  ntt_addr_gen u_addr_gen (
    .clk      (clk),
    .reset    (reset),
    .init     (w_init),
    .advance  (w_advance),
    .addr_a   (w_addr_a),
    .addr_b   (w_addr_b),
    .zeta_idx (w_zeta_idx),
    .last     (w_last)
  );

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state logic; start is only looked at in IDLE, bt_valid only in WAIT.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (start) w_state_nxt = READ;
      READ:    w_state_nxt = LOAD;
      LOAD:    w_state_nxt = ISSUE;
      ISSUE:   w_state_nxt = WAIT;
      WAIT:    if (bt_valid) w_state_nxt = WRITE;
      WRITE:   w_state_nxt = w_last ? DONE : READ;
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Strobes and addresses; addresses are forced to zero outside a transform.
  always_comb begin
    logic w_active;
    w_active  = (r_state != IDLE) && (r_state != DONE);
    busy      = w_active;
    done      = (r_state == DONE);
    rd_en     = (r_state == READ);
    bt_en     = (r_state == ISSUE);
    wr_en     = (r_state == WRITE);
    rd_addr_a = w_active ? w_addr_a   : '0;
    rd_addr_b = w_active ? w_addr_b   : '0;
    wr_addr_a = w_active ? w_addr_a   : '0;
    wr_addr_b = w_active ? w_addr_b   : '0;
    zeta_idx  = w_active ? w_zeta_idx : '0;
  end

  // Operand capture in LOAD; held until the next butterfly's LOAD.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_bt_a <= '0;
      r_bt_b <= '0;
    end else if (r_state == LOAD) begin
      r_bt_a <= rd_data_a;
      r_bt_b <= rd_data_b;
    end
  end

  // Result capture on the completion pulse while waiting.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_data_a <= '0;
      r_wr_data_b <= '0;
    end else if ((r_state == WAIT) && bt_valid) begin
      r_wr_data_a <= bt_a_res;
      r_wr_data_b <= bt_b_res;
    end
  end

  assign bt_a      = r_bt_a;
  assign bt_b      = r_bt_b;
  assign wr_data_a = r_wr_data_a;
  assign wr_data_b = r_wr_data_b;

`ifdef NTT_CTRL_CYCLE_CNT_EN
  logic [15:0] r_cycle_cnt;

  // Busy-cycle counter: cleared on accept, saturating, frozen while idle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                                 r_cycle_cnt <= '0;
    else if (w_init)                            r_cycle_cnt <= '0;
    else if (busy && (r_cycle_cnt != 16'hFFFF)) r_cycle_cnt <= r_cycle_cnt + 16'd1;
  end

  assign cycle_cnt = r_cycle_cnt;
`endif

endmodule

`default_nettype wire

// File: tb/tb_ntt_ctrl.sv
// ============================================================================
// Module      : tb_ntt_ctrl
// Description : Scoreboard bench for ntt_ctrl with behavioural RAM,
//               butterfly unit, zeta ROM and a direct-evaluation NTT
//               reference mod 7681. Covers NTT_CTRL_CYCLE_CNT_EN when defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ntt_ctrl;
  import ntt_pkg::*;

  typedef struct {
    int a;
    int b;
    int k;
    int cyc;
  } exp_t;

  logic               clk = 1'b0;
  logic               reset = 1'b0;
  logic               start = 1'b0;
  logic               busy, done, rd_en, bt_en, wr_en;
  logic [ADDR_W-1:0]  rd_addr_a, rd_addr_b, zeta_idx, wr_addr_a, wr_addr_b;
  logic [BIT_LEN-1:0] rd_data_a = '0, rd_data_b = '0;
  logic [BIT_LEN-1:0] bt_a, bt_b, wr_data_a, wr_data_b;
  logic [BIT_LEN-1:0] bt_a_res = '0, bt_b_res = '0;
  logic               bt_valid = 1'b0;
`ifdef NTT_CTRL_CYCLE_CNT_EN
  logic [15:0]        cycle_cnt;
`endif

  ntt_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .rd_en     (rd_en),
    .rd_addr_a (rd_addr_a),
    .rd_addr_b (rd_addr_b),
    .rd_data_a (rd_data_a),
    .rd_data_b (rd_data_b),
    .zeta_idx  (zeta_idx),
    .bt_en     (bt_en),
    .bt_a      (bt_a),
    .bt_b      (bt_b),
    .bt_a_res  (bt_a_res),
    .bt_b_res  (bt_b_res),
    .bt_valid  (bt_valid),
    .wr_en     (wr_en),
    .wr_addr_a (wr_addr_a),
    .wr_addr_b (wr_addr_b),
    .wr_data_a (wr_data_a),
    .wr_data_b (wr_data_b)
`ifdef NTT_CTRL_CYCLE_CNT_EN
    ,
    .cycle_cnt (cycle_cnt)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;
  int t0 = 0;
  int mem[N];
  int src[N];
  int refo[N];
  int zt[N];
  int psi;
  exp_t q_rd[$], q_bt[$], q_wr[$];
  int q_res_a[$], q_res_b[$];
  int n_bt, n_wr;
  bit done_seen;
  bit inject_en;
  bit rd_pend;
  int pa, pb;
  int bt_cnt;
  int pend_a, pend_b;

  task automatic chk(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, expv);
    end
  endtask

  function automatic int modpow(input int b, input int e);
    longint r = 1;
    longint x = longint'(b % Q);
    int ee = e;
    while (ee > 0) begin
      if (ee[0]) r = (r * x) % Q;
      x = (x * x) % Q;
      ee = ee >> 1;
    end
    return int'(r);
  endfunction

  function automatic int brv8(input int v);
    int r = 0;
    for (int i = 0; i < 8; i++) if (v[i]) r = r | (1 << (7 - i));
    return r;
  endfunction

  // Primitive 512th root of unity and twiddle ROM zeta[k] = psi^brv8(k).
  task automatic build_zetas();
    psi = 0;
    for (int x = 2; x < Q && psi == 0; x++) begin
      int c;
      c = modpow(x, 15);
      if (modpow(c, 256) == Q - 1) psi = c;
    end
    for (int k = 0; k < N; k++) zt[k] = modpow(psi, brv8(k));
  endtask

  // Negacyclic NTT by direct evaluation: out[i] = f(psi^(2*brv8(i)+1)).
  task automatic ref_ntt();
    for (int i = 0; i < N; i++) begin
      longint w, p, acc;
      w = longint'(modpow(psi, 2 * brv8(i) + 1));
      p = 1;
      acc = 0;
      for (int j = 0; j < N; j++) begin
        acc = (acc + longint'(src[j]) * p) % Q;
        p = (p * w) % Q;
      end
      refo[i] = int'(acc);
    end
  endtask

  task automatic load_random();
    for (int i = 0; i < N; i++) begin
      src[i] = int'($urandom_range(0, Q - 1));
      mem[i] = src[i];
    end
  endtask

  task automatic clear_sb();
    q_rd.delete(); q_bt.delete(); q_wr.delete();
    q_res_a.delete(); q_res_b.delete();
    n_bt = 0; n_wr = 0; done_seen = 0;
    rd_pend = 0; bt_cnt = 0; bt_valid = 1'b0;
  endtask

  // Expected butterfly schedule straight from the loop nest; 8 cycles each.
  task automatic do_start();
    int n = 0;
    int k = 0;
    clear_sb();
    for (int len = N / 2; len > 0; len = len / 2)
      for (int s = 0; s < N; s += 2 * len) begin
        k++;
        for (int j = s; j < s + len; j++) begin
          q_rd.push_back('{j, j + len, k, 8 * n + 1});
          q_bt.push_back('{j, j + len, k, 8 * n + 3});
          q_wr.push_back('{j, j + len, k, 8 * n + 8});
          n++;
        end
      end
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    t0 = cyc;
    start = 1'b0;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 9000 && !done_seen; i++) begin
      @(negedge clk);
      #1;
    end
    if (!done_seen) chk("done_timeout", 0, 1);
  endtask

  task automatic chk_all_zero(input string name);
    chk(name, int'(|{busy, done, rd_en, rd_addr_a, rd_addr_b, zeta_idx, bt_en, bt_a, bt_b,
                     wr_en, wr_addr_a, wr_addr_b, wr_data_a, wr_data_b}), 0);
  endtask

  task automatic cmp_ram(input string name, input bit delta);
    int nbad = 0;
    for (int i = 0; i < N; i++)
      if (mem[i] != (delta ? 1 : refo[i])) nbad++;
    chk(name, nbad, 0);
  endtask

  // Monitor + environment models: RAM, butterfly unit, scoreboard checks.
  initial begin
    forever begin
      @(negedge clk);
      begin
        int rel;
        rel = cyc - t0 + 1;
        bt_valid = 1'b0;
        if (rd_pend) begin
          rd_data_a = BIT_LEN'(mem[pa]);
          rd_data_b = BIT_LEN'(mem[pb]);
          rd_pend = 0;
        end
        if (bt_cnt > 0) begin
          bt_cnt--;
          if (bt_cnt == 0) begin
            bt_valid = 1'b1;
            bt_a_res = BIT_LEN'(pend_a);
            bt_b_res = BIT_LEN'(pend_b);
          end
        end else if (inject_en && rd_en && $urandom_range(0, 3) == 0) begin
          bt_valid = 1'b1;
          bt_a_res = BIT_LEN'($urandom_range(0, Q - 1));
          bt_b_res = BIT_LEN'($urandom_range(0, Q - 1));
        end
        if (reset) begin
          if (rd_en) begin
            if (q_rd.size() == 0) chk("rd_unexpected", 1, 0);
            else begin
              exp_t e;
              e = q_rd.pop_front();
              chk("rd_addr_a", int'(rd_addr_a), e.a);
              chk("rd_addr_b", int'(rd_addr_b), e.b);
              chk("rd_zeta", int'(zeta_idx), e.k);
              chk("rd_cycle", rel, e.cyc);
            end
            rd_pend = 1;
            pa = int'(rd_addr_a);
            pb = int'(rd_addr_b);
          end
          if (bt_en) begin
            longint t;
            n_bt++;
            if (q_bt.size() == 0) chk("bt_unexpected", 1, 0);
            else begin
              exp_t e;
              e = q_bt.pop_front();
              chk("bt_zeta", int'(zeta_idx), e.k);
              chk("bt_cycle", rel, e.cyc);
              chk("bt_a", int'(bt_a), mem[e.a]);
              chk("bt_b", int'(bt_b), mem[e.b]);
            end
            t = (longint'(zt[zeta_idx]) * longint'(bt_b)) % Q;
            pend_a = int'((longint'(bt_a) + t) % Q);
            pend_b = int'((longint'(bt_a) - t + Q) % Q);
            q_res_a.push_back(pend_a);
            q_res_b.push_back(pend_b);
            bt_cnt = 4;
          end
          if (wr_en) begin
            n_wr++;
            if (q_wr.size() == 0 || q_res_a.size() == 0) chk("wr_unexpected", 1, 0);
            else begin
              exp_t e;
              e = q_wr.pop_front();
              chk("wr_addr_a", int'(wr_addr_a), e.a);
              chk("wr_addr_b", int'(wr_addr_b), e.b);
              chk("wr_cycle", rel, e.cyc);
              chk("wr_data_a", int'(wr_data_a), q_res_a.pop_front());
              chk("wr_data_b", int'(wr_data_b), q_res_b.pop_front());
            end
            mem[wr_addr_a] = int'(wr_data_a);
            mem[wr_addr_b] = int'(wr_data_b);
          end
          if (done) begin
            chk("done_cycle", rel, 8193);
            chk("done_busy", int'(busy), 0);
            chk("bt_count", n_bt, 1024);
            chk("wr_count", n_wr, 1024);
            chk("sb_left", q_rd.size() + q_bt.size() + q_wr.size(), 0);
            done_seen = 1;
          end
        end
      end
    end
  end

  initial begin
    build_zetas();
    clear_sb();
    inject_en = 0;
    repeat (3) @(negedge clk);
    chk_all_zero("reset_outputs");
    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk_all_zero("idle_outputs");

    // Run 1: delta input with stray bt_valid pulses outside WAIT.
    inject_en = 1;
    for (int i = 0; i < N; i++) mem[i] = (i == 0) ? 1 : 0;
    do_start();
    wait_done();
    @(negedge clk);
    #1;
    chk("post_done_busy_done", int'({busy, done}), 0);
    cmp_ram("delta_result", 1'b1);

    // Run 2: random input, start re-pulsed at cycle 100.
    load_random();
    ref_ntt();
    do_start();
`ifdef NTT_CTRL_CYCLE_CNT_EN
    @(negedge clk);
    #1;
    chk("cnt_cleared", int'(cycle_cnt), 0);
`endif
    while (cyc - t0 + 1 < 100) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done();
`ifdef NTT_CTRL_CYCLE_CNT_EN
    chk("cnt_at_done", int'(cycle_cnt), 8192);
    repeat (10) @(negedge clk);
    #1;
    chk("cnt_idle_hold", int'(cycle_cnt), 8192);
`endif
    cmp_ram("random_result", 1'b0);
    inject_en = 0;

    // Run 3: asynchronous reset at cycle 500, then a fresh transform.
    load_random();
    do_start();
    while (cyc - t0 + 1 < 500) @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    chk_all_zero("midrun_reset_outputs");
    clear_sb();
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (5) @(negedge clk);
    load_random();
    ref_ntt();
    do_start();
    wait_done();
    cmp_ram("restart_result", 1'b0);

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
